// File: rtl/binary_to_disp7_pkg.sv
// Shared types and segment constants for the sequential binary-to-7-segment driver.
// Segment bytes are active-low, bit0=a .. bit6=g, bit7=dp.
package binary_to_disp7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Codes 10..15 cannot come out of a valid BCD digit and show as blank.
  localparam logic [7:0] SEG_DIGIT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// One decimal digit to active-low segments; dash overrides blank, blank overrides the digit.
module seg7_encoder
  import binary_to_disp7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DIGIT[digit];
    if (blank) seg = SEG_BLANK;
    if (dash)  seg = SEG_DASH;
  end

endmodule

// File: rtl/binary_to_disp7_seq.sv
// Iterative double-dabble binary-to-BCD converter driving N_DIGITS active-low 7-segment digits,
// with optional leading-zero blanking and a dashed overflow display.
module binary_to_disp7_seq
  import binary_to_disp7_pkg::*;
#(
  parameter int IN_WIDTH      = 10,
  parameter int N_DIGITS      = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   number_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [8*N_DIGITS-1:0] disp_out
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int CMP_W = (IN_WIDTH > 32) ? IN_WIDTH : 32;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(10 ** N_DIGITS);

  if ((IN_WIDTH < 4) || (N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_param_check
    $fatal(1, "binary_to_disp7_seq: IN_WIDTH must be >= 4 and N_DIGITS in 1..8");
  end

  state_t state, state_next;

  logic [IN_WIDTH-1:0]       shreg;
  logic [BCD_W-1:0]          bcd;
  logic [BCD_W-1:0]          bcd_adj;
  logic [BCD_W+IN_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]          cnt;
  logic                      ovf;
  logic [N_DIGITS-1:0]       blank_vec;
  logic                      zero_above;
  logic [8*N_DIGITS-1:0]     seg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < N_DIGITS; k++) begin
      bcd_adj[4*k +: 4] = add3(bcd[4*k +: 4]);
    end
  end

  // Bits pushed out of the top nibble are dropped; they only matter when ovf is set anyway.
  assign shifted = {bcd_adj, shreg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= number_in;
            bcd   <= '0;
            cnt   <= CNT_W'(IN_WIDTH);
            ovf   <= (CMP_W'(number_in) >= LIMIT);
          end
        end
        CONVERT: begin
          {bcd, shreg} <= shifted;
          cnt          <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Scan from the most significant digit; a digit blanks while everything above it is zero.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above   = zero_above & (bcd[4*k +: 4] == 4'd0);
      blank_vec[k] = (BLANK_LEADING != 0) && zero_above && (k != 0);
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
    seg7_encoder u_enc (
      .digit (bcd[4*g +: 4]),
      .blank (blank_vec[g]),
      .dash  (ovf),
      .seg   (seg_next[8*g +: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_out <= {N_DIGITS{SEG_BLANK}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        disp_out <= seg_next;
        overflow <= ovf;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_binary_to_disp7_seq.sv
// Randomized and directed checks of binary_to_disp7_seq in three configurations
// against a decimal-arithmetic reference model.
module tb_binary_to_disp7_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_w;
  logic [9:0]  num_a;
  logic [15:0] num_w;

  logic        busy_a, done_a, ovf_a;
  logic [23:0] disp_a;
  logic        busy_n, done_n, ovf_n;
  logic [23:0] disp_n;
  logic        busy_w, done_w, ovf_w;
  logic [39:0] disp_w;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  binary_to_disp7_seq #(.IN_WIDTH(10), .N_DIGITS(3), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .number_in(num_a), .start(start_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .disp_out(disp_a));

  binary_to_disp7_seq #(.IN_WIDTH(10), .N_DIGITS(3), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .number_in(num_a), .start(start_a),
    .busy(busy_n), .done(done_n), .overflow(ovf_n), .disp_out(disp_n));

  binary_to_disp7_seq #(.IN_WIDTH(16), .N_DIGITS(5), .BLANK_LEADING(1)) dut_w (
    .clk(clk), .rst(rst), .number_in(num_w), .start(start_w),
    .busy(busy_w), .done(done_w), .overflow(ovf_w), .disp_out(disp_w));

  function automatic logic [63:0] modelDisp(input longint value, input int ndig, input bit blankLead);
    logic [7:0]  segTable [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [63:0] res = '0;
    longint      p = 1;
    longint      limit = 1;
    for (int k = 0; k < ndig; k++) limit = limit * 10;
    for (int k = 0; k < ndig; k++) begin
      if (value >= limit)                        res[8*k +: 8] = 8'hBF;
      else if (blankLead && k > 0 && value < p)  res[8*k +: 8] = 8'hFF;
      else                                       res[8*k +: 8] = segTable[int'((value / p) % 10)];
      p = p * 10;
    end
    return res;
  endfunction

  function automatic logic modelOvf(input longint value, input int ndig);
    longint limit = 1;
    for (int k = 0; k < ndig; k++) limit = limit * 10;
    return value >= limit;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left on a falling edge; pulses start on all instances and checks the results.
  task automatic applyStimulus(input logic [9:0] va, input logic [15:0] vw);
    int busyCnt = 0, pulsesA = 0, pulsesN = 0, pulsesW = 0, tA = 0, tW = 0;
    num_a = va; num_w = vw; start_a = 1'b1; start_w = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_w = 1'b0;
    num_a = 10'($urandom); num_w = 16'($urandom);
    if (busy_a) busyCnt++;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      num_a = 10'($urandom); num_w = 16'($urandom);
      if (busy_a) busyCnt++;
      if (done_a) begin pulsesA++; if (tA == 0) tA = n; end
      if (done_n) pulsesN++;
      if (done_w) begin pulsesW++; if (tW == 0) tW = n; end
    end
    checkOutput("latency_a", 64'(tA), 64'd11);
    checkOutput("latency_w", 64'(tW), 64'd17);
    checkOutput("busy_cycles_a", 64'(busyCnt), 64'd11);
    checkOutput("done_pulses_a", 64'(pulsesA), 64'd1);
    checkOutput("done_pulses_n", 64'(pulsesN), 64'd1);
    checkOutput("done_pulses_w", 64'(pulsesW), 64'd1);
    checkOutput($sformatf("disp_a(%0d)", va), 64'(disp_a), modelDisp(longint'(va), 3, 1'b1));
    checkOutput($sformatf("ovf_a(%0d)", va), 64'(ovf_a), 64'(modelOvf(longint'(va), 3)));
    checkOutput($sformatf("disp_nb(%0d)", va), 64'(disp_n), modelDisp(longint'(va), 3, 1'b0));
    checkOutput($sformatf("ovf_nb(%0d)", va), 64'(ovf_n), 64'(modelOvf(longint'(va), 3)));
    checkOutput($sformatf("disp_w(%0d)", vw), 64'(disp_w), modelDisp(longint'(vw), 5, 1'b1));
    checkOutput($sformatf("ovf_w(%0d)", vw), 64'(ovf_w), 64'(modelOvf(longint'(vw), 5)));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'({busy_a, busy_n, busy_w}), 64'd0);
    checkOutput({tag, "_done"}, 64'({done_a, done_n, done_w}), 64'd0);
    checkOutput({tag, "_ovf"},  64'({ovf_a, ovf_n, ovf_w}), 64'd0);
    checkOutput({tag, "_disp_a"}, 64'(disp_a), 64'hFFFFFF);
    checkOutput({tag, "_disp_nb"}, 64'(disp_n), 64'hFFFFFF);
    checkOutput({tag, "_disp_w"}, 64'(disp_w), 64'hFF_FFFF_FFFF);
  endtask

  task automatic resetMidOp(input bit immediateStart);
    int stray = 0;
    num_a = 10'd1000; num_w = 16'd4321; start_a = 1'b1; start_w = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_w = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetState("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    if (immediateStart) begin
      applyStimulus(10'($urandom), 16'($urandom));
    end else begin
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (done_a || done_n || done_w) stray++;
      end
      checkOutput("no_done_after_reset", 64'(stray), 64'd0);
      checkResetState("after_release");
    end
  endtask

  task automatic streamTest();
    logic [9:0] vals [0:79];
    int lastDone = -1, doneSeen = 0, firstDone = -1;
    start_a = 1'b1;
    for (int c = 0; c < 80; c++) begin
      num_a   = 10'($urandom);
      vals[c] = num_a;
      @(negedge clk);
      if (done_a) begin
        if (c < 11) begin
          checkOutput("stream_early_done", 64'(c), 64'd11);
        end else begin
          checkOutput($sformatf("stream_disp@%0d", c), 64'(disp_a),
                      modelDisp(longint'(vals[c-11]), 3, 1'b1));
          checkOutput($sformatf("stream_ovf@%0d", c), 64'(ovf_a),
                      64'(modelOvf(longint'(vals[c-11]), 3)));
        end
        if (lastDone >= 0) checkOutput("stream_gap", 64'(c - lastDone), 64'd12);
        else firstDone = c;
        lastDone = c;
        doneSeen++;
      end
    end
    start_a = 1'b0;
    checkOutput("stream_first_done", 64'(firstDone), 64'd11);
    checkOutput("stream_done_count", 64'(doneSeen), 64'd6);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  dirA [7] = '{10'd987, 10'd0, 10'd5, 10'd40, 10'd1000, 10'd1023, 10'd999};
    logic [15:0] dirW [7] = '{16'd65535, 16'd0, 16'd7, 16'd10000, 16'd12345, 16'd100, 16'd9};
    rst = 1'b1; start_a = 1'b0; start_w = 1'b0; num_a = '0; num_w = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(dirA[i], dirW[i]);

    resetMidOp(1'b0);
    resetMidOp(1'b1);

    streamTest();

    for (int i = 0; i < 200; i++) applyStimulus(10'($urandom), 16'($urandom));

    for (int v = 0; v < 1024; v++) applyStimulus(10'(v), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
